combin_line_ctrl: RTL and testbench
===================================

Name: combin_line_ctrl

Overview:
Line/frame sequencer that sits in front of `combin_data` on the VDMA write path. It accepts a pixel stream and drives the packer's `iwr_en`/`idata`/`ialign`/`ilast` (packer in MODE="LINE"). It counts packed words returned by the packer and, per completed line, issues one write-burst request (address, length) to the AXI write master. It also enforces frame geometry and flags stream-format errors.

Parameters:
ISIZE, 24, pixel width in bits (matches packer ISIZE)
OSIZE, 256, packed word width in bits (matches packer OSIZE)
ADDR_W, 32, byte-address width
DIM_W, 12, width of hsize/vsize/counters
LEN_W, 8, burst length field width (words)

Ports:
clock  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  pulse: arm for one frame (sampled only in IDLE)
cfg_abort  in  1  pulse: abandon frame
cfg_base  in  ADDR_W  frame base byte address (latched on start)
cfg_stride  in  ADDR_W  line stride in bytes (latched on start)
cfg_hsize  in  DIM_W  pixels per line, ≥1 (latched on start)
cfg_vsize  in  DIM_W  lines per frame, ≥1 (latched on start)
s_valid  in  1  pixel valid
s_ready  out  1  pixel accept
s_data  in  ISIZE  pixel
s_sof  in  1  first pixel of frame
s_eol  in  1  last pixel of line
pk_wr_en  out  1  to packer iwr_en
pk_data  out  ISIZE  to packer idata
pk_align  out  1  to packer ialign
pk_last  out  1  to packer ilast
pk_owr_en  in  1  from packer owr_en
pk_olast_en  in  1  from packer olast_en
req_valid  out  1  burst request valid
req_ready  in  1  burst request accept
req_addr  out  ADDR_W  line start address
req_len  out  LEN_W  packed words in line
busy  out  1  not IDLE
frame_done  out  1  one-cycle pulse at frame end
err_sof  out  1  sticky: sof seen mid-frame
err_eol  out  1  sticky: s_eol disagrees with hsize
line_idx  out  DIM_W  current line number

Behaviour:
- All state is updated on the clock edge. Synchronous reset `rst`=1 forces:
  - state IDLE;
  - every output 0, including the sticky errors and line_idx.
- pk_* outputs are combinational from the accepted beat:
  - pk_wr_en = s_valid & s_ready & state∈{WAIT_SOF(sof beat), LINE};
  - pk_data = s_data.
- FSM states: IDLE, WAIT_SOF, LINE, DRAIN, REQ.
- IDLE:
  - s_ready=0.
  - cfg_start → latch cfg_*; line_idx=0; clear sticky errors; go to WAIT_SOF.
- WAIT_SOF:
  - s_ready=1.
  - Beats without s_sof are discarded; no pk_wr_en.
  - A beat with s_sof is pixel 0 of line 0. It drives pk_wr_en=1 and pk_align=1 in the same cycle, sets pix_cnt=1, and goes to LINE.
  - If hsize==1, that beat also asserts pk_last and the FSM goes to DRAIN.
- LINE:
  - s_ready=1.
  - Each accepted beat forwards with pk_wr_en=1 and increments pix_cnt.
  - pk_last = (pix_cnt==hsize-1) on the accepted beat. The line ends on that beat regardless of s_eol.
  - err_eol sets if s_eol≠pk_last on any accepted beat.
  - An s_sof beat in LINE sets err_sof and is treated as an ordinary pixel.
  - pk_align is asserted only on the sof beat of line 0. Later lines rely on the packer's line-mode reset via ilast.
  - On the last-pixel beat → DRAIN.
- word_cnt (LEN_W):
  - cleared on entry to LINE/WAIT_SOF-first-beat;
  - incremented on every pk_owr_en during LINE and DRAIN, saturating at all-ones.
- DRAIN:
  - s_ready=0.
  - Waits for pk_olast_en; a pk_owr_en in the same cycle is counted.
  - Then it latches req_len=word_cnt (including that cycle's increment) and req_addr=cfg_base+line_idx*cfg_stride, and goes to REQ.
  - The address is computed by accumulator (addr_acc+=stride per line); no multiplier.
- REQ:
  - req_valid=1; req_addr and req_len are held stable until req_ready.
  - On req_valid&req_ready:
    - if line_idx==vsize-1 → frame_done pulse, go to IDLE;
    - else line_idx++, pix_cnt=0, go to LINE.
- Line 1 onward begins directly in LINE; the first accepted beat is pixel 0, with no sof required.
- cfg_abort:
  - In WAIT_SOF/LINE/DRAIN → IDLE next cycle, s_ready=0, no request issued.
  - In REQ, the abort is recorded and the FSM stays until the handshake completes, then goes to IDLE; valid never drops without ready.
- cfg_start outside IDLE is ignored. cfg_start and cfg_abort together in IDLE: abort wins.
- busy = (state≠IDLE).

Decomposition:
- Package combin_ctrl_pkg holds:
  - the state enum typedef (IDLE, WAIT_SOF, LINE, DRAIN, REQ);
  - a req_t struct {addr, len};
  - localparam WORDS_MAX = 2**LEN_W-1.
- One natural sub-module: combin_line_addr_gen, the base/stride accumulator with load/step. The FSM stays in the top module.

Test Plan:
1. hsize=32, vsize=2, base=0x1000, stride=0x400, packer returns 3 owr_en + olast_en per line → two requests {0x1000,3}, {0x1400,3}; frame_done one cycle after the 2nd handshake; err_* stay 0.
2. Three beats without sof, then sof → discarded beats give no pk_wr_en; pk_align=1 and pk_wr_en=1 exactly on the sof beat.
3. hsize=4, s_eol asserted on the 3rd beat → pk_last on the 4th beat; err_eol=1; line still requests.
4. req_ready held low 10 cycles in REQ → req_valid and addr/len stable throughout; s_ready=0; a cfg_abort pulse mid-wait → FSM goes to IDLE only after the handshake.
5. cfg_abort during LINE at pix_cnt=5 → next cycle busy=0, s_ready=0, no req_valid; a subsequent cfg_start runs a clean frame.
6. rst asserted in DRAIN → next cycle all outputs 0, state IDLE; pk_olast_en arriving afterwards is ignored.

Source files
------------

// File: rtl/combin_ctrl_pkg.sv
// combin_ctrl_pkg: shared states, request record and limits for the combin line controller
package combin_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH = 8;
  localparam int WORDS_MAX = 2**LEN_WIDTH-1;
  typedef enum logic [2:0] {IDLE, WAIT_SOF, LINE, DRAIN, REQ} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } req_t;
endpackage

// File: rtl/combin_line_addr_gen.sv
// combin_line_addr_gen: line start address accumulator, loaded with base and stepped by stride
module combin_line_addr_gen
  import combin_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] addr_d, addr_q;
  always_comb addr_d = load ? base : step ? addr_q + stride : addr_q;
  always_ff @(posedge clock) addr_q <= rst ? '0 : addr_d;
  assign addr = addr_q;
endmodule

// File: rtl/combin_line_ctrl.sv
// combin_line_ctrl: line/frame sequencer feeding the packer and issuing one burst request per line
module combin_line_ctrl
  import combin_ctrl_pkg::*;
#(
  parameter int ISIZE  = 24,
  parameter int OSIZE  = 256,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DIM_W  = 12,
  parameter int LEN_W  = LEN_WIDTH
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [DIM_W-1:0]  cfg_hsize,
  input  logic [DIM_W-1:0]  cfg_vsize,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ISIZE-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              pk_wr_en,
  output logic [ISIZE-1:0]  pk_data,
  output logic              pk_align,
  output logic              pk_last,
  input  logic              pk_owr_en,
  input  logic              pk_olast_en,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LEN_W-1:0]  req_len,
  output logic              busy,
  output logic              frame_done,
  output logic              err_sof,
  output logic              err_eol,
  output logic [DIM_W-1:0]  line_idx
);
  if (OSIZE < ISIZE) begin : g_size_check
    $error("OSIZE must be at least ISIZE");
  end
  state_t            state_d, state_q;
  logic [DIM_W-1:0]  hsize_d, hsize_q, vsize_d, vsize_q;
  logic [DIM_W-1:0]  pix_cnt_d, pix_cnt_q, line_d, line_q;
  logic [ADDR_W-1:0] stride_d, stride_q, line_addr;
  logic [LEN_W-1:0]  word_cnt_d, word_cnt_q, word_inc;
  req_t              req_d, req_q;
  logic              abort_d, abort_q, err_sof_d, err_sof_q, err_eol_d, err_eol_q;
  logic              frame_done_d, frame_done_q;
  logic              addr_load, addr_step, last_pix, last_line;
  combin_line_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clock (clock),
    .rst   (rst),
    .load  (addr_load),
    .step  (addr_step),
    .base  (cfg_base),
    .stride(stride_q),
    .addr  (line_addr)
  );
  always_comb begin
    state_d      = state_q;
    hsize_d      = hsize_q;
    vsize_d      = vsize_q;
    stride_d     = stride_q;
    pix_cnt_d    = pix_cnt_q;
    word_cnt_d   = word_cnt_q;
    line_d       = line_q;
    req_d        = req_q;
    abort_d      = abort_q;
    err_sof_d    = err_sof_q;
    err_eol_d    = err_eol_q;
    frame_done_d = 1'b0;
    addr_load    = 1'b0;
    addr_step    = 1'b0;
    pk_wr_en     = 1'b0;
    pk_align     = 1'b0;
    pk_last      = 1'b0;
    s_ready      = state_q == WAIT_SOF || state_q == LINE;
    last_pix     = pix_cnt_q == hsize_q - DIM_W'(1);
    last_line    = line_q == vsize_q - DIM_W'(1);
    word_inc     = word_cnt_q == LEN_W'(WORDS_MAX) ? word_cnt_q : word_cnt_q + LEN_W'(1);
    case (state_q)
      IDLE: if (cfg_start && !cfg_abort) begin
        state_d   = WAIT_SOF;
        hsize_d   = cfg_hsize;
        vsize_d   = cfg_vsize;
        stride_d  = cfg_stride;
        line_d    = '0;
        err_sof_d = 1'b0;
        err_eol_d = 1'b0;
        abort_d   = 1'b0;
        addr_load = 1'b1;
      end
      WAIT_SOF: if (s_valid && s_sof) begin
        pk_wr_en   = 1'b1;
        pk_align   = 1'b1;
        pk_last    = hsize_q == DIM_W'(1);
        pix_cnt_d  = DIM_W'(1);
        word_cnt_d = '0;
        err_eol_d  = err_eol_q | (s_eol != pk_last);
        state_d    = pk_last ? DRAIN : LINE;
      end
      LINE: begin
        word_cnt_d = pk_owr_en ? word_inc : word_cnt_q;
        if (s_valid) begin
          pk_wr_en  = 1'b1;
          pk_last   = last_pix;
          pix_cnt_d = pix_cnt_q + DIM_W'(1);
          err_eol_d = err_eol_q | (s_eol != last_pix);
          err_sof_d = err_sof_q | s_sof;
          state_d   = last_pix ? DRAIN : LINE;
        end
      end
      DRAIN: begin
        word_cnt_d = pk_owr_en ? word_inc : word_cnt_q;
        if (pk_olast_en) begin
          req_d.addr = line_addr;
          req_d.len  = word_cnt_d;
          state_d    = REQ;
        end
      end
      REQ: begin
        abort_d = abort_q | cfg_abort;
        if (req_ready) begin
          state_d      = (abort_d || last_line) ? IDLE : LINE;
          frame_done_d = !abort_d && last_line;
          if (!abort_d && !last_line) begin
            line_d     = line_q + DIM_W'(1);
            pix_cnt_d  = '0;
            word_cnt_d = '0;
            addr_step  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (cfg_abort && (state_q == WAIT_SOF || state_q == LINE || state_q == DRAIN)) state_d = IDLE;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      hsize_q      <= '0;
      vsize_q      <= '0;
      stride_q     <= '0;
      pix_cnt_q    <= '0;
      word_cnt_q   <= '0;
      line_q       <= '0;
      req_q        <= '0;
      abort_q      <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hsize_q      <= hsize_d;
      vsize_q      <= vsize_d;
      stride_q     <= stride_d;
      pix_cnt_q    <= pix_cnt_d;
      word_cnt_q   <= word_cnt_d;
      line_q       <= line_d;
      req_q        <= req_d;
      abort_q      <= abort_d;
      err_sof_q    <= err_sof_d;
      err_eol_q    <= err_eol_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign pk_data    = s_data;
  assign req_valid  = state_q == REQ;
  assign req_addr   = req_q.addr;
  assign req_len    = req_q.len;
  assign busy       = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign err_sof    = err_sof_q;
  assign err_eol    = err_eol_q;
  assign line_idx   = line_q;
endmodule

// File: tb/tb_combin_line_ctrl.sv
// tb_combin_line_ctrl: directed self-checking bench for combin_line_ctrl
module tb_combin_line_ctrl;
  logic        clock = 1'b0;
  logic        rst, cfg_start, cfg_abort;
  logic [31:0] cfg_base, cfg_stride;
  logic [11:0] cfg_hsize, cfg_vsize;
  logic        s_valid, s_ready, s_sof, s_eol;
  logic [23:0] s_data, pk_data;
  logic        pk_wr_en, pk_align, pk_last, pk_owr_en, pk_olast_en;
  logic        req_valid, req_ready, busy, frame_done, err_sof, err_eol;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [11:0] line_idx;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  combin_line_ctrl dut (
    .clock(clock), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_hsize(cfg_hsize), .cfg_vsize(cfg_vsize),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .pk_wr_en(pk_wr_en), .pk_data(pk_data), .pk_align(pk_align), .pk_last(pk_last),
    .pk_owr_en(pk_owr_en), .pk_olast_en(pk_olast_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .busy(busy), .frame_done(frame_done), .err_sof(err_sof), .err_eol(err_eol), .line_idx(line_idx)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clr();
    cfg_start = 0; cfg_abort = 0; s_valid = 0; s_sof = 0; s_eol = 0;
    pk_owr_en = 0; pk_olast_en = 0; req_ready = 0;
  endtask
  task automatic start(input logic [31:0] b, input logic [31:0] st, input int hs, input int vs);
    cfg_base = b; cfg_stride = st; cfg_hsize = 12'(hs); cfg_vsize = 12'(vs); cfg_start = 1;
    tick();
    cfg_start = 0;
    #1;
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
  endtask
  task automatic sof_beat(input logic eol, input logic exp_last);
    s_valid = 1; s_sof = 1; s_eol = eol; s_data = 24'hABCDEF;
    #1;
    chk("sof_wr_en", pk_wr_en, 1);
    chk("sof_align", pk_align, 1);
    chk("sof_last", pk_last, exp_last);
    chk("sof_data", pk_data, 24'hABCDEF);
    tick();
    clr();
  endtask
  task automatic beats(input int first, input int n, input int hs, input int eol_pix,
                       input int sof_pix, input int owr_a, input int owr_b);
    for (int p = first; p < first + n; p++) begin
      s_valid = 1; s_data = 24'(p); s_eol = (p == eol_pix); s_sof = (p == sof_pix);
      pk_owr_en = (p == owr_a) || (p == owr_b);
      #1;
      chk("beat_wr_en", pk_wr_en, 1);
      chk("beat_align", pk_align, 0);
      chk("beat_last", pk_last, p == hs - 1);
      tick();
    end
    clr();
  endtask
  task automatic drain(input logic owr);
    #1;
    chk("drain_ready", s_ready, 0);
    chk("drain_req", req_valid, 0);
    pk_olast_en = 1; pk_owr_en = owr;
    tick();
    clr();
  endtask
  task automatic handshake();
    req_ready = 1;
    tick();
    req_ready = 0;
    #1;
  endtask
  initial begin
    rst = 1; clr(); cfg_base = 0; cfg_stride = 0; cfg_hsize = 0; cfg_vsize = 0; s_data = 0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_line_idx", line_idx, 0);
    chk("rst_errs", {err_sof, err_eol, frame_done}, 0);
    chk("rst_req", {req_addr, req_len}, 0);
    // frame of two 32-pixel lines, with three ignored pre-sof beats
    start(32'h1000, 32'h400, 32, 2);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = 24'(i + 100);
      #1;
      chk("discard_wr_en", pk_wr_en, 0);
      tick();
    end
    clr();
    sof_beat(0, 0);
    beats(1, 31, 32, 31, -1, 10, 20);
    drain(1);
    chk("l0_req_valid", req_valid, 1);
    chk("l0_req_addr", req_addr, 32'h1000);
    chk("l0_req_len", req_len, 3);
    chk("l0_ready", s_ready, 0);
    handshake();
    chk("l1_line_idx", line_idx, 1);
    chk("l1_frame_done", frame_done, 0);
    chk("l1_ready", s_ready, 1);
    beats(0, 32, 32, 31, -1, 5, 15);
    drain(1);
    chk("l1_req_addr", req_addr, 32'h1400);
    chk("l1_req_len", req_len, 3);
    handshake();
    chk("f1_frame_done", frame_done, 1);
    chk("f1_busy", busy, 0);
    chk("f1_errs", {err_sof, err_eol}, 0);
    tick();
    chk("f1_done_pulse", frame_done, 0);
    // early eol on a 4-pixel line, then a stalled request with a mid-wait abort
    start(32'h2000, 32'h100, 4, 2);
    sof_beat(0, 0);
    beats(1, 3, 4, 2, -1, 1, -1);
    chk("eol_err", err_eol, 1);
    drain(1);
    for (int i = 0; i < 10; i++) begin
      cfg_abort = (i == 4);
      #1;
      chk("stall_valid", req_valid, 1);
      chk("stall_addr", req_addr, 32'h2000);
      chk("stall_len", req_len, 2);
      chk("stall_ready", s_ready, 0);
      tick();
    end
    cfg_abort = 0;
    chk("stall_busy", busy, 1);
    handshake();
    chk("abort_req_busy", busy, 0);
    chk("abort_req_valid", req_valid, 0);
    chk("abort_req_done", frame_done, 0);
    // abort mid-line, then a clean 2-pixel frame
    start(32'h3000, 32'h40, 16, 1);
    chk("restart_err_eol", err_eol, 0);
    sof_beat(0, 0);
    beats(1, 4, 16, -1, -1, -1, -1);
    cfg_abort = 1; s_valid = 1;
    tick();
    clr();
    chk("abort_busy", busy, 0);
    chk("abort_ready", s_ready, 0);
    chk("abort_req", req_valid, 0);
    tick();
    chk("abort_req_later", req_valid, 0);
    start(32'h3000, 32'h40, 2, 1);
    sof_beat(0, 0);
    beats(1, 1, 2, 1, -1, 1, -1);
    drain(0);
    chk("clean_addr", req_addr, 32'h3000);
    chk("clean_len", req_len, 1);
    handshake();
    chk("clean_done", frame_done, 1);
    chk("clean_errs", {err_sof, err_eol}, 0);
    // single-pixel line
    start(32'h4000, 32'h10, 1, 1);
    sof_beat(1, 1);
    drain(1);
    chk("h1_addr", req_addr, 32'h4000);
    chk("h1_len", req_len, 1);
    chk("h1_err_eol", err_eol, 0);
    handshake();
    chk("h1_done", frame_done, 1);
    // sof inside a line, then reset while draining
    start(32'h5000, 32'h10, 3, 1);
    sof_beat(0, 0);
    beats(1, 2, 3, 2, 1, -1, -1);
    chk("mid_sof_err", err_sof, 1);
    chk("drain_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("drst_busy", busy, 0);
    chk("drst_ready", s_ready, 0);
    chk("drst_req", {req_valid, req_addr, req_len}, 0);
    chk("drst_errs", {err_sof, err_eol, frame_done}, 0);
    chk("drst_line_idx", line_idx, 0);
    pk_olast_en = 1; pk_owr_en = 1;
    tick(); tick();
    clr();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_req", req_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
